// File: rtl/fpu_seq_if.sv
// fpu_seq_if: start/done handshake bundle between an FP requester and fpu_seq
interface fpu_seq_if #(parameter int EXP_W = 8, parameter int MAN_W = 23);
  localparam int W = 1 + EXP_W + MAN_W;
  logic start;
  logic [2:0] fpu_op;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic busy;
  logic done;
  logic [W-1:0] out;
  logic cc;
  modport master (output start, fpu_op, in1, in2, input busy, done, out, cc);
  modport slave (input start, fpu_op, in1, in2, output busy, done, out, cc);
endinterface

// File: rtl/fpu_seq.sv
// fpu_seq: multi-cycle parametrised FP add/sub/compare/move unit with start/done handshake
module fpu_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter logic [2:0] ADD = 3'h0,
  parameter logic [2:0] SUB = 3'h1,
  parameter logic [2:0] EQ = 3'h2,
  parameter logic [2:0] LT = 3'h3,
  parameter logic [2:0] GT = 3'h4,
  parameter logic [2:0] LE = 3'h5,
  parameter logic [2:0] GE = 3'h6,
  parameter logic [2:0] MOV = 3'h7
) (
  input logic clk,
  input logic rst_n,
  fpu_seq_if.slave bus
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int M = MAN_W + 4;
  localparam int LW = $clog2(M + 1);
  typedef logic [EXP_W+1:0] ew_t;
  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND} st_t;
  st_t state;
  logic [W-1:0] a_r, b_r, spv_r;
  logic sp_r, sgn_r, eop_r;
  ew_t e_r;
  logic [M-1:0] ml_r, ms_r;
  logic [M:0] sum_r;
  // Magnitude-ordered less-than where -0 and +0 are equal
  function automatic logic lt_f(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x[W-1] != y[W-1]) return x[W-1] & ((|x[W-2:0]) | (|y[W-2:0]));
    return x[W-1] ? (x[W-2:0] > y[W-2:0]) : (x[W-2:0] < y[W-2:0]);
  endfunction
  logic sa, sb, za, zb, na, nb, ia, ib, swap, nan, sp;
  logic [EXP_W-1:0] ea, eb, el, es, diff;
  logic [MAN_W-1:0] fa, fb;
  logic [MAN_W:0] ha, hb, hl, hs;
  logic [2*M-1:0] sh;
  logic [M-1:0] ms;
  logic [W-1:0] spv;
  // Unpack, classify specials, order by magnitude and align the smaller operand
  always_comb begin
    {sa, ea, fa} = a_r;
    {sb, eb, fb} = b_r;
    za = ea == '0;
    zb = eb == '0;
    na = (&ea) & (|fa);
    nb = (&eb) & (|fb);
    ia = (&ea) & ~(|fa);
    ib = (&eb) & ~(|fb);
    ha = za ? '0 : {1'b1, fa};
    hb = zb ? '0 : {1'b1, fb};
    swap = (zb ? '0 : {eb, fb}) > (za ? '0 : {ea, fa});
    el = swap ? eb : ea;
    es = swap ? ea : eb;
    hl = swap ? hb : ha;
    hs = swap ? ha : hb;
    diff = el - es;
    sh = {hs, 3'b000, {M{1'b0}}} >> diff;
    ms = 32'(diff) > M - 1 ? {{(M-1){1'b0}}, |hs} : {sh[2*M-1:M+1], sh[M] | (|sh[M-1:0])};
    nan = na | nb | (ia & ib & (sa != sb));
    sp = nan | ia | ib;
    spv = nan ? {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}} :
          ia ? {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end
  logic [LW-1:0] lz;
  logic [M-1:0] mn;
  ew_t en, ef;
  logic uf, of, zero, inc, ovf;
  logic [MAN_W+1:0] r;
  logic [MAN_W-1:0] fr;
  logic [W-1:0] res;
  // Normalise the registered sum and round it to nearest-even into the final word
  always_comb begin
    lz = '0;
    for (int i = 0; i < M; i++) if (sum_r[i]) lz = LW'(M - 1 - i);
    zero = ~(|sum_r);
    mn = sum_r[M] ? {sum_r[M:2], sum_r[1] | sum_r[0]} : sum_r[M-1:0] << lz;
    en = sum_r[M] ? e_r + ew_t'(1) : e_r - ew_t'(lz);
    uf = ~sum_r[M] & (ew_t'(lz) >= e_r);
    inc = mn[2] & (mn[1] | mn[0] | mn[3]);
    r = {1'b0, mn[M-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    ovf = r[MAN_W+1];
    fr = ovf ? r[MAN_W:1] : r[MAN_W-1:0];
    ef = en + {{(EXP_W+1){1'b0}}, ovf};
    of = ef >= {2'b00, {EXP_W{1'b1}}};
    res = sp_r ? spv_r :
          zero ? {~eop_r & sgn_r, {(W-1){1'b0}}} :
          uf ? {sgn_r, {(W-1){1'b0}}} :
          of ? {sgn_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}} : {sgn_r, ef[EXP_W-1:0], fr};
  end
  logic c_nan, c_eq, c_lt, c_gt, flag;
  // Compare flag for the single-cycle compare ops; any NaN forces false
  always_comb begin
    c_nan = ((&bus.in1[W-2:MAN_W]) & (|bus.in1[MAN_W-1:0])) | ((&bus.in2[W-2:MAN_W]) & (|bus.in2[MAN_W-1:0]));
    c_eq = (bus.in1 == bus.in2) | (~(|bus.in1[W-2:0]) & ~(|bus.in2[W-2:0]));
    c_lt = lt_f(bus.in1, bus.in2);
    c_gt = lt_f(bus.in2, bus.in1);
    flag = ~c_nan & (bus.fpu_op == EQ ? c_eq : bus.fpu_op == LT ? c_lt : bus.fpu_op == GT ? c_gt :
                     bus.fpu_op == LE ? (c_lt | c_eq) : bus.fpu_op == GE ? (c_gt | c_eq) : 1'b0);
  end
  // Sequencer; rounding is folded into the NORM->ROUND edge so out/done are registered in the done cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.out <= '0;
      bus.cc <= 1'b0;
      a_r <= '0;
      b_r <= '0;
      spv_r <= '0;
      sp_r <= 1'b0;
      sgn_r <= 1'b0;
      eop_r <= 1'b0;
      e_r <= '0;
      ml_r <= '0;
      ms_r <= '0;
      sum_r <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        S_ALIGN: begin
          state <= S_ADD;
          sp_r <= sp;
          spv_r <= spv;
          sgn_r <= swap ? sb : sa;
          eop_r <= sa ^ sb;
          e_r <= {2'b00, el};
          ml_r <= {hl, 3'b000};
          ms_r <= ms;
        end
        S_ADD: begin
          state <= S_NORM;
          sum_r <= eop_r ? {1'b0, ml_r} - {1'b0, ms_r} : {1'b0, ml_r} + {1'b0, ms_r};
        end
        S_NORM: begin
          state <= S_ROUND;
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          bus.out <= res;
        end
        default: begin
          state <= S_IDLE;
          if (bus.start && (bus.fpu_op == ADD || bus.fpu_op == SUB)) begin
            state <= S_ALIGN;
            bus.busy <= 1'b1;
            a_r <= bus.in1;
            b_r <= {bus.in2[W-1] ^ (bus.fpu_op == SUB), bus.in2[W-2:0]};
          end else if (bus.start) begin
            bus.done <= 1'b1;
            bus.out <= bus.fpu_op == MOV ? bus.in1 : {{(W-1){1'b0}}, flag};
            if (bus.fpu_op != MOV) bus.cc <= flag;
          end
        end
      endcase
    end
  end
endmodule
